dice_game_ctrl: RTL and testbench

//   Sequencing FSM for the two-dice game datapath. Turns a debounced roll pulse into a

---
 rtl/dice_game_ctrl.sv | 140 ++++++++++++++
 tb/tb_dice_game_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dice_game_ctrl.sv
// rtl/dice_game_ctrl.sv - two-dice game sequencing FSM with round/win/loss counters
// Optional feature macro DICE_STREAK_EN adds longest consecutive-win tracking on best_streak.
module dice_game_ctrl #(
  parameter int ROUNDS   = 7,
  parameter int CNT_BITS = 4,
  parameter int SETTLE   = 2
) (
  input  logic                clk,
  input  logic                r,
  input  logic                roll,
  input  logic [3:0]          die1,
  input  logic [3:0]          die2,
  output logic                rnd_step,
  output logic                busy,
  output logic                result_vld,
  output logic [1:0]          result,
  output logic [CNT_BITS-1:0] point,
  output logic [CNT_BITS-1:0] rounds,
  output logic [CNT_BITS-1:0] wins,
  output logic [CNT_BITS-1:0] losses,
  output logic                game_over,
  output logic [CNT_BITS-1:0] best_streak
);
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_COMEOUT, S_POINT, S_STEP, S_WAIT, S_EVAL, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [WW-1:0]       r_wait;
  logic [CNT_BITS-1:0] r_point, r_rounds, r_wins, r_losses;
  logic [1:0]          r_result;
  logic                r_vld;
  logic [4:0]          w_sum;
  logic                w_illegal, w_win, w_lose, w_eval, w_last, w_wait_done;
  logic [CNT_BITS-1:0] w_rounds_inc;

  assign w_sum        = {1'b0, die1} + {1'b0, die2};
  assign w_illegal    = (die1 == 4'd0) || (die1 > 4'd6) || (die2 == 4'd0) || (die2 > 4'd6);
  assign w_eval       = (r_state == S_EVAL) && !w_illegal;
  assign w_rounds_inc = r_rounds + CNT_BITS'(1);
  assign w_last       = (w_rounds_inc == CNT_BITS'(ROUNDS));
  assign w_wait_done  = (r_wait == WW'(SETTLE - 1));

  // A point value of zero means the round is still in its come-out phase
  always_comb begin
    w_win  = 1'b0;
    w_lose = 1'b0;
    if (r_point == '0) begin
      w_win  = (w_sum == 5'd7) || (w_sum == 5'd11);
      w_lose = (w_sum == 5'd2) || (w_sum == 5'd3) || (w_sum == 5'd12);
    end else begin
      w_win  = (w_sum == 5'(r_point));
      w_lose = !w_win && (w_sum == 5'd7);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COMEOUT, S_POINT: if (roll) w_next = S_STEP;
      S_STEP:             w_next = S_WAIT;
      S_WAIT:             if (w_wait_done) w_next = S_EVAL;
      S_EVAL: begin
        if (w_illegal)            w_next = S_STEP;
        else if (w_win || w_lose) w_next = w_last ? S_DONE : S_COMEOUT;
        else                      w_next = S_POINT;
      end
      S_DONE:             w_next = S_DONE;
      default:            w_next = S_COMEOUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= S_COMEOUT;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (r_state == S_WAIT && !w_wait_done) ? r_wait + WW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      r_vld    <= 1'b0;
      r_result <= 2'b00;
      r_point  <= '0;
      r_rounds <= '0;
      r_wins   <= '0;
      r_losses <= '0;
    end else begin
      r_vld <= 1'b0;
      if (w_eval) begin
        r_vld <= 1'b1;
        if (w_win || w_lose) begin
          r_result <= w_win ? 2'b01 : 2'b10;
          r_rounds <= w_rounds_inc;
          r_point  <= '0;
          if (w_win) r_wins   <= r_wins + CNT_BITS'(1);
          else       r_losses <= r_losses + CNT_BITS'(1);
        end else begin
          r_result <= 2'b11;
          if (r_point == '0) r_point <= CNT_BITS'(w_sum);
        end
      end
    end
  end

`ifdef DICE_STREAK_EN
  logic [CNT_BITS-1:0] r_cur, r_best, w_cur_inc;

  assign w_cur_inc = (r_cur == '1) ? r_cur : r_cur + CNT_BITS'(1);

  always_ff @(posedge clk) begin
    if (r) begin
      r_cur  <= '0;
      r_best <= '0;
    end else if (w_eval && w_win) begin
      r_cur <= w_cur_inc;
      if (w_cur_inc > r_best) r_best <= w_cur_inc;
    end else if (w_eval && w_lose) begin
      r_cur <= '0;
    end
  end

  assign best_streak = r_best;
`else
  assign best_streak = '0;
`endif

  assign rnd_step   = (r_state == S_STEP);
  assign busy       = (r_state == S_STEP) || (r_state == S_WAIT) || (r_state == S_EVAL);
  assign game_over  = (r_state == S_DONE);
  assign result_vld = r_vld;
  assign result     = r_result;
  assign point      = r_point;
  assign rounds     = r_rounds;
  assign wins       = r_wins;
  assign losses     = r_losses;
endmodule

// File: tb/tb_dice_game_ctrl.sv
// tb/tb_dice_game_ctrl.sv - directed self-checking bench for dice_game_ctrl (SETTLE=2, ROUNDS=7)
module tb_dice_game_ctrl;
  logic       clk = 1'b0;
  logic       r = 1'b0;
  logic       roll = 1'b0;
  logic [3:0] die1 = 4'd1;
  logic [3:0] die2 = 4'd1;
  logic       rnd_step, busy, result_vld, game_over;
  logic [1:0] result;
  logic [3:0] point, rounds, wins, losses, best_streak;

  int nvec = 0;
  int nerr = 0;

  dice_game_ctrl #(.ROUNDS(7), .CNT_BITS(4), .SETTLE(2)) dut (
    .clk(clk), .r(r), .roll(roll), .die1(die1), .die2(die2),
    .rnd_step(rnd_step), .busy(busy), .result_vld(result_vld), .result(result),
    .point(point), .rounds(rounds), .wins(wins), .losses(losses),
    .game_over(game_over), .best_streak(best_streak)
  );

  always #5 clk = ~clk;

  // Pulses roll for one cycle and waits (bounded) for result_vld; reports where things happened
  task automatic roll_and_wait(input logic [3:0] d1, input logic [3:0] d2,
                               output int lat, output int step_at, output int steps, output bit got);
    die1 = d1; die2 = d2; roll = 1'b1;
    @(negedge clk);
    roll = 1'b0;
    lat = 0; step_at = 0; steps = 0; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (rnd_step) begin steps++; if (step_at == 0) step_at = i; end
      if (result_vld) begin got = 1'b1; lat = i; end
      else @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    r = 1'b1; roll = 1'b1;
    @(negedge clk); @(negedge clk);
    r = 1'b0; roll = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    nvec++; if ({rnd_step, busy, result_vld, game_over} !== 4'b0000) begin nerr++; $display("FAIL reset_flags got %b exp 0000", {rnd_step, busy, result_vld, game_over}); end
    nvec++; if ({result, point, rounds, wins, losses, best_streak} !== 22'd0) begin nerr++; $display("FAIL reset_values got %h exp 0", {result, point, rounds, wins, losses, best_streak}); end
  endtask

  task automatic test_natural();
    int lat, sa, st; bit got;
    roll_and_wait(4'd3, 4'd4, lat, sa, st, got);
    nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL nat_timeout got %b exp 1", got); end
    nvec++; if (sa !== 1) begin nerr++; $display("FAIL nat_step_latency got %0d exp 1", sa); end
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL nat_vld_latency got %0d exp 5", lat); end
    nvec++; if ({result, rounds, wins, losses} !== {2'b01, 4'd1, 4'd1, 4'd0}) begin nerr++; $display("FAIL nat_result got %b/%0d/%0d/%0d exp 01/1/1/0", result, rounds, wins, losses); end
  endtask

  task automatic test_craps();
    int lat, sa, st; bit got;
    roll_and_wait(4'd1, 4'd1, lat, sa, st, got);
    nvec++; if ({got, result, losses, point, rounds} !== {1'b1, 2'b10, 4'd1, 4'd0, 4'd2}) begin nerr++; $display("FAIL craps got vld=%b res=%b l=%0d p=%0d rnd=%0d exp 1/10/1/0/2", got, result, losses, point, rounds); end
  endtask

  task automatic test_point_win();
    int lat, sa, st; bit got;
    roll_and_wait(4'd2, 4'd2, lat, sa, st, got);
    nvec++; if ({got, result, point, rounds} !== {1'b1, 2'b11, 4'd4, 4'd2}) begin nerr++; $display("FAIL pset got vld=%b res=%b p=%0d rnd=%0d exp 1/11/4/2", got, result, point, rounds); end
    @(negedge clk);
    nvec++; if ({result_vld, result, point} !== {1'b0, 2'b11, 4'd4}) begin nerr++; $display("FAIL phold got vld=%b res=%b p=%0d exp 0/11/4", result_vld, result, point); end
    roll_and_wait(4'd3, 4'd3, lat, sa, st, got);
    nvec++; if ({got, result, point} !== {1'b1, 2'b11, 4'd4}) begin nerr++; $display("FAIL pnone got vld=%b res=%b p=%0d exp 1/11/4", got, result, point); end
    roll_and_wait(4'd1, 4'd3, lat, sa, st, got);
    nvec++; if ({got, result, point, rounds, wins} !== {1'b1, 2'b01, 4'd0, 4'd3, 4'd2}) begin nerr++; $display("FAIL pwin got vld=%b res=%b p=%0d rnd=%0d w=%0d exp 1/01/0/3/2", got, result, point, rounds, wins); end
  endtask

  task automatic test_point_lose_busy();
    int lat, sa, st; bit got;
    int steps, vld_at;
    roll_and_wait(4'd3, 4'd3, lat, sa, st, got);
    nvec++; if ({got, result, point} !== {1'b1, 2'b11, 4'd6}) begin nerr++; $display("FAIL p6set got vld=%b res=%b p=%0d exp 1/11/6", got, result, point); end
    die1 = 4'd5; die2 = 4'd2; roll = 1'b1;
    steps = 0; vld_at = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      roll = (i <= 3);
      if (rnd_step) steps++;
      if (result_vld && vld_at == 0) vld_at = i;
    end
    nvec++; if (steps !== 1) begin nerr++; $display("FAIL busy_drop got %0d steps exp 1", steps); end
    nvec++; if (vld_at !== 5) begin nerr++; $display("FAIL seven_out_latency got %0d exp 5", vld_at); end
    nvec++; if ({result, losses, point, rounds} !== {2'b10, 4'd2, 4'd0, 4'd4}) begin nerr++; $display("FAIL seven_out got res=%b l=%0d p=%0d rnd=%0d exp 10/2/0/4", result, losses, point, rounds); end
  endtask

  task automatic test_illegal_reset();
    int steps, vld_at;
    die1 = 4'd0; die2 = 4'd3; roll = 1'b1;
    steps = 0; vld_at = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      roll = 1'b0;
      if (rnd_step) steps++;
      if (result_vld && vld_at == 0) vld_at = i;
      if (i == 5) begin
        nvec++; if (rnd_step !== 1'b1) begin nerr++; $display("FAIL reroll_step got %b exp 1", rnd_step); end
        die1 = 4'd6; die2 = 4'd5;
      end
    end
    nvec++; if (steps !== 2) begin nerr++; $display("FAIL reroll_count got %0d exp 2", steps); end
    nvec++; if (vld_at !== 9) begin nerr++; $display("FAIL reroll_vld got %0d exp 9", vld_at); end
    nvec++; if ({result, wins, rounds} !== {2'b01, 4'd3, 4'd5}) begin nerr++; $display("FAIL reroll_win got res=%b w=%0d rnd=%0d exp 01/3/5", result, wins, rounds); end
    die1 = 4'd2; die2 = 4'd2; roll = 1'b1;
    @(negedge clk); roll = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL wait_busy got %b exp 1", busy); end
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    nvec++; if ({rnd_step, busy, result_vld, game_over, result, point, rounds, wins, losses, best_streak} !== 26'd0) begin nerr++; $display("FAIL mid_reset got %h exp 0", {rnd_step, busy, result_vld, game_over, result, point, rounds, wins, losses, best_streak}); end
  endtask

  task automatic test_full_game();
    logic [3:0] d1s [7] = '{4'd3, 4'd5, 4'd1, 4'd6, 4'd5, 4'd3, 4'd6};
    logic [3:0] d2s [7] = '{4'd4, 4'd6, 4'd1, 4'd1, 4'd6, 4'd4, 4'd6};
    logic [3:0] exp_best;
    int lat, sa, st, steps; bit got;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      roll_and_wait(d1s[i], d2s[i], lat, sa, st, got);
      nvec++; if (got !== 1'b1) begin nerr++; $display("FAIL game_round%0d timeout", i); end
    end
`ifdef DICE_STREAK_EN
    exp_best = 4'd3;
`else
    exp_best = 4'd0;
`endif
    @(negedge clk);
    nvec++; if ({game_over, rounds, wins, losses} !== {1'b1, 4'd7, 4'd5, 4'd2}) begin nerr++; $display("FAIL game_end got go=%b rnd=%0d w=%0d l=%0d exp 1/7/5/2", game_over, rounds, wins, losses); end
    nvec++; if (best_streak !== exp_best) begin nerr++; $display("FAIL best_streak got %0d exp %0d", best_streak, exp_best); end
    die1 = 4'd3; die2 = 4'd4; roll = 1'b1;
    steps = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      roll = 1'b0;
      if (rnd_step) steps++;
    end
    nvec++; if ({steps, game_over, rounds} !== {32'd0, 1'b1, 4'd7}) begin nerr++; $display("FAIL done_ignore got steps=%0d go=%b rnd=%0d exp 0/1/7", steps, game_over, rounds); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_natural();
    test_craps();
    test_point_win();
    test_point_lose_busy();
    test_illegal_reset();
    test_full_game();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
